// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Optional signed mode (sgn port) is enabled by defining SEQ_MULTIPLIER_SIGNED_EN.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state_o
);

  // Handshake: start is accepted on any edge where the block is in IDLE or DONE;
  // busy is high for exactly WIDTH cycles after acceptance, then done pulses for
  // one cycle with product already valid. start while busy is ignored.

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic             op_neg;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   upper_sum;
  logic [PW:0]      pre_shift;
  logic [PW-1:0]    acc_step;
  logic             accept;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  // Signed operands are reduced to magnitudes; the sign is reapplied on the final write.
  assign op_a   = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign op_b   = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign op_neg = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_neg = 1'b0;
`endif

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign addend    = b_q[0] ? a_q : '0;
  assign upper_sum = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
  assign pre_shift = {upper_sum, acc_q[WIDTH-1:0]};
  assign acc_step  = pre_shift[PW:1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    neg_d     = neg_q;

    if (accept) begin
      state_d = RUN;
      a_d     = op_a;
      b_d     = op_b;
      neg_d   = op_neg;
      acc_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          acc_d = acc_step;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cnt_d     = '0;
            product_d = neg_q ? (~acc_step + PW'(1)) : acc_step;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule
